// File: rtl/fifo_stream_reader_if.sv
// Purpose : bundles the FIFO read side and the outgoing valid/ready stream of fifo_stream_reader.
// Ports   : fifo_empty/fifo_data/fifo_rd face the FIFO; m_valid/m_ready/m_data (and m_last when
//           FIFO_STREAM_LAST_EN is defined) face the stream sink. master = reader view, slave = environment view.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
`ifdef FIFO_STREAM_LAST_EN
    logic                  m_last;
`endif

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_rd,
        output m_valid,
`ifdef FIFO_STREAM_LAST_EN
        output m_last,
`endif
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_rd,
        input  m_valid,
`ifdef FIFO_STREAM_LAST_EN
        input  m_last,
`endif
        input  m_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Purpose : pulls words from a 1-cycle-latency FIFO into a small buffer and streams them out valid/ready.
// Latency : FIFO read issued in cycle N, captured at the N+1 edge, m_valid in cycle N+2; 1 beat/clk sustained.
// Backpressure: m_ready low fills the buffer, then fifo_rd stays low; no word is ever dropped or overrun.
//
// Ports: clk/rst (synchronous, active-high), bus (fifo_stream_reader_if.master):
//   fifo_empty/fifo_data in, fifo_rd out, m_valid/m_data out, m_ready in, m_last out (optional).
// Optional feature macro: FIFO_STREAM_LAST_EN adds m_last driven by a PKT_LEN beat counter.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2,
    parameter int PKT_LEN    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    fifo_stream_reader_if.master     bus
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW = $clog2(BUF_DEPTH) + 1;
    localparam int AW = OW + 1;

    if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || PKT_LEN < 1) begin : g_bad_param
        $error("fifo_stream_reader: BUF_DEPTH must be a power of two >= 2 and PKT_LEN >= 1");
    end

    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [OW-1:0]         occ;
    logic                  infl;      // a FIFO read was issued last cycle; its data is on fifo_data now
    logic                  valid;
    logic                  pop;
    logic                  rd_issue;
    logic [AW-1:0]         occ_after;

    // Occupancy counts the in-flight word as already owned so a read is only
    // issued when a buffer slot is guaranteed. The m_ready -> pop -> fifo_rd
    // path is combinational by design and must be budgeted in timing.
    always_comb begin
        valid     = (occ != '0);
        pop       = valid && bus.m_ready;
        occ_after = AW'(occ) + AW'(infl) - AW'(pop);
        rd_issue  = !rst && !bus.fifo_empty && (occ_after < AW'(BUF_DEPTH));
    end

    assign bus.fifo_rd = rd_issue;
    assign bus.m_valid = valid;
    // Gated so the output reads zero whenever nothing is buffered, including after reset.
    assign bus.m_data  = valid ? buf_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= '0;
            infl   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            infl <= rd_issue;
            occ  <= occ_after[OW-1:0];
            if (infl) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Buffer storage carries no reset; pointers and occupancy define what is live.
    always_ff @(posedge clk) begin
        if (!rst && infl) begin
            buf_mem[wr_ptr] <= bus.fifo_data;
        end
    end

`ifdef FIFO_STREAM_LAST_EN
    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    logic [CW-1:0] beat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (pop) begin
            if (beat_cnt == CW'(PKT_LEN - 1)) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    assign bus.m_last = valid && (beat_cnt == CW'(PKT_LEN - 1));
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Purpose : directed and randomised checks of fifo_stream_reader against a behavioural 1-cycle-latency FIFO.
// Latency : outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: m_ready held low, released and randomised to exercise buffer full and drain.
module tb_fifo_stream_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_stream_reader_if #(.DATA_WIDTH(8)) bus ();

    fifo_stream_reader #(
        .DATA_WIDTH (8),
        .BUF_DEPTH  (2),
        .PKT_LEN    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: read data appears the cycle after fifo_rd; reset flushes it.
    logic [7:0] mem [2048];
    int head = 0;
    int tail = 0;
    int rd_count = 0;

    assign bus.fifo_empty = (head == tail);

    always @(posedge clk) begin
        if (rst) begin
            head <= tail;
        end else if (bus.fifo_rd) begin
            bus.fifo_data <= mem[head % 2048];
            head          <= head + 1;
            rd_count      <= rd_count + 1;
        end
    end

    int total = 0;
    int bad = 0;
    int exp_beat = 0;
    bit chk_last = 1'b0;
    logic [7:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        mem[tail % 2048] = v;
        tail++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_beat = 0;
    endtask

    // Expects n consecutive values starting at first, with m_ready already high.
    task automatic collect(input int n, input logic [7:0] first, input string tag);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 20 * n + 20) begin
            if (bus.m_valid && bus.m_ready) begin
                check(tag, 32'(bus.m_data), 32'(first + 8'(got)));
`ifdef FIFO_STREAM_LAST_EN
                if (chk_last) check({tag, "_last"}, 32'(bus.m_last), 32'(exp_beat == 3));
`endif
                exp_beat = (exp_beat + 1) % 4;
                got++;
            end
            tick();
            cyc++;
        end
        check({tag, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        int rd0;
        int got;
        int sent;
        int cycles;
        int max_occ;
        int unstable;
        bit prev_hold;
        logic [7:0] prev_data;
        logic [7:0] v;

        // Reset state
        bus.m_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        check("rst_occ", 32'(dut.occ), 32'd0);
        check("rst_infl", 32'(dut.infl), 32'd0);
        check("rst_ptrs", 32'({dut.wr_ptr, dut.rd_ptr}), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_fifo_rd", 32'(bus.fifo_rd), 32'd0);

        // Basic latency: single word 0xA5
        push(8'hA5);
        #1;
        check("lat_rd_n", 32'(bus.fifo_rd), 32'd1);
        tick();
        check("lat_rd_pulse", 32'(bus.fifo_rd), 32'd0);
        check("lat_valid_n1", 32'(bus.m_valid), 32'd0);
        tick();
        check("lat_valid_n2", 32'(bus.m_valid), 32'd1);
        check("lat_data_n2", 32'(bus.m_data), 32'hA5);
        tick();
        check("lat_valid_after", 32'(bus.m_valid), 32'd0);

        // Throughput: 0x01..0x08 on consecutive cycles
        for (int i = 1; i <= 8; i++) push(8'(i));
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            check("tput_valid", 32'(bus.m_valid), 32'd1);
            check("tput_data", 32'(bus.m_data), 32'(i + 1));
            tick();
        end
        check("tput_drained", 32'(bus.m_valid), 32'd0);
        check("tput_rd_off", 32'(bus.fifo_rd), 32'd0);

        // Backpressure: 0x10..0x17 held off for 10 cycles
        bus.m_ready = 1'b0;
        rd0 = rd_count;
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        repeat (10) tick();
        check("bp_occ_full", 32'(dut.occ), 32'd2);
        check("bp_rd_off", 32'(bus.fifo_rd), 32'd0);
        check("bp_reads", 32'(rd_count - rd0), 32'd2);
        check("bp_valid", 32'(bus.m_valid), 32'd1);
        check("bp_data_held", 32'(bus.m_data), 32'h10);
        bus.m_ready = 1'b1;
        collect(8, 8'h10, "bp_drain");

        // Random m_ready and random FIFO writes, 1000 words
        got = 0;
        sent = 0;
        cycles = 0;
        max_occ = 0;
        unstable = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        while (got < 1000 && cycles < 20000) begin
            if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
            if (prev_hold && !(bus.m_valid && bus.m_data == prev_data)) unstable++;
            bus.m_ready = 1'($urandom_range(0, 1));
            if (bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    check("rand_extra_beat", 32'(bus.m_valid), 32'd0);
                end else begin
                    check("rand_data", 32'(bus.m_data), 32'(sb.pop_front()));
                end
                got++;
            end
            prev_hold = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            if (sent < 1000 && $urandom_range(0, 1) == 1) begin
                v = 8'($urandom);
                push(v);
                sb.push_back(v);
                sent++;
            end
            tick();
            cycles++;
        end
        check("rand_count", 32'(got), 32'd1000);
        check("rand_occ_bound", 32'(max_occ <= 2), 32'd1);
        check("rand_stable", 32'(unstable), 32'd0);

        // Reset mid-stream with a buffered beat and a word in flight
        bus.m_ready = 1'b0;
        push(8'h30);
        push(8'h31);
        push(8'h32);
        tick();
        tick();
        check("mrst_pre_valid", 32'(bus.m_valid), 32'd1);
        check("mrst_pre_infl", 32'(dut.infl), 32'd1);
        rst = 1'b1;
        #1;
        check("mrst_rd_off", 32'(bus.fifo_rd), 32'd0);
        tick();
        check("mrst_valid", 32'(bus.m_valid), 32'd0);
        check("mrst_occ", 32'(dut.occ), 32'd0);
        rst = 1'b0;
        exp_beat = 0;
        bus.m_ready = 1'b1;
        push(8'h3C);
        collect(1, 8'h3C, "mrst_first");
        tick();
        check("mrst_no_stale", 32'(bus.m_valid), 32'd0);

`ifdef FIFO_STREAM_LAST_EN
        // Packet framing: last on beats 4 and 8; reset restarts the count
        do_reset();
        chk_last = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        collect(8, 8'h40, "pkt8");
        for (int i = 0; i < 2; i++) push(8'(8'h50 + i));
        collect(2, 8'h50, "pkt2");
        do_reset();
        for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
        collect(4, 8'h60, "pkt4");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
